cv_mem_arbiter: RTL

- Shares the single external SRAM/SDRAM byte port between three requesters: the Z80 (post-decode, physical address), the ADAM PCB/EOS DMA engine (disk/tape block buffers), and the HPS ioctl cartridge/ROM loader.
- Sits between the address decoder / page mapping logic and the memory pins.
- Sequences each access through a fixed-timing FSM.
- Stalls the Z80 through WAIT and prevents DMA starvation with an aging counter.

---
 rtl/cv_mem_pkg.sv | 20 ++
 rtl/cv_mem_prio_sel.sv | 29 ++
 rtl/cv_mem_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cv_mem_pkg.sv
// Shared types for the external memory arbiter: FSM states, requester ids.
package cv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    // Enum values double as bit positions in the request/grant vectors.
    typedef enum logic [1:0] {
        REQ_LD,
        REQ_CPU,
        REQ_DMA
    } req_id_t;

    localparam int NUM_REQ = 3;

endpackage

// File: rtl/cv_mem_prio_sel.sv
// Combinational winner select: loader > CPU > DMA, except that a starved DMA beats everyone.
module cv_mem_prio_sel
    import cv_mem_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               starve_sat,
    output logic [NUM_REQ-1:0] gnt,
    output req_id_t            id
);

    always_comb begin
        gnt = '0;
        id  = REQ_LD;
        if (req[2] && starve_sat) begin
            gnt[2] = 1'b1;
            id     = REQ_DMA;
        end else if (req[0]) begin
            gnt[0] = 1'b1;
            id     = REQ_LD;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
            id     = REQ_CPU;
        end else if (req[2]) begin
            gnt[2] = 1'b1;
            id     = REQ_DMA;
        end
    end

endmodule

// File: rtl/cv_mem_arbiter.sv
// Shares the external byte-wide memory port between the HPS loader, the Z80 and the ADAM DMA
// engine using a fixed-timing IDLE/SETUP/ACCESS/DONE sequence with DMA anti-starvation aging.
module cv_mem_arbiter
    import cv_mem_pkg::*;
#(
    parameter int ADDR_W     = 20,
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk_i,
    input  logic              reset_n_i,

    input  logic              ld_req_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [7:0]        ld_d_i,
    output logic              ld_ack_o,

    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [7:0]        cpu_d_i,
    output logic [7:0]        cpu_d_o,
    output logic              cpu_wait_n_o,

    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [7:0]        dma_d_i,
    output logic [7:0]        dma_d_o,
    output logic              dma_ack_o,

    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_d_o,
    input  logic [7:0]        mem_d_i,
    output logic              mem_ce_n_o,
    output logic              mem_we_n_o,
    output logic              mem_oe_n_o
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          cnt;
    logic                last;

    logic [NUM_REQ-1:0]  req;
    logic [NUM_REQ-1:0]  gnt;
    logic                any_gnt;
    req_id_t             win_id;

    logic [SW-1:0]       starve;
    logic                starve_sat;
    logic                cpu_done;

    logic                we;
    req_id_t             id;
    logic [ADDR_W-1:0]   addr;
    logic [7:0]          wdata;

    // A CPU cycle that has already been served must not compete again until req drops.
    assign req        = {dma_req_i, cpu_req_i & ~cpu_done, ld_req_i};
    assign starve_sat = (starve == SW'(STARVE_MAX));
    assign any_gnt    = |gnt;
    assign last       = (cnt == 4'(LAT - 1));

    cv_mem_prio_sel u_prio_sel (
        .req        (req),
        .starve_sat (starve_sat),
        .gnt        (gnt),
        .id         (win_id)
    );

    assign cpu_wait_n_o = ~(cpu_req_i & ~cpu_done);
    assign mem_addr_o   = addr;
    assign mem_d_o      = wdata;

    always_comb begin
        state_nxt  = state;
        mem_ce_n_o = 1'b1;
        mem_we_n_o = 1'b1;
        mem_oe_n_o = 1'b1;
        case (state)
            IDLE: begin
                if (any_gnt) state_nxt = SETUP;
            end
            SETUP: begin
                mem_ce_n_o = 1'b0;
                mem_oe_n_o = we;
                state_nxt  = ACCESS;
            end
            ACCESS: begin
                mem_ce_n_o = 1'b0;
                mem_we_n_o = ~we;
                mem_oe_n_o = we;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == SETUP)
                cnt <= '0;
            else if (state == ACCESS)
                cnt <= cnt + 4'd1;
        end
    end

    // Winner's request is captured at the IDLE->SETUP edge and held through DONE.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            addr  <= '0;
            wdata <= '0;
            we    <= 1'b0;
            id    <= REQ_LD;
        end else if (state == IDLE && any_gnt) begin
            id <= win_id;
            case (win_id)
                REQ_LD: begin
                    addr  <= ld_addr_i;
                    wdata <= ld_d_i;
                    we    <= 1'b1;
                end
                REQ_CPU: begin
                    addr  <= cpu_addr_i;
                    wdata <= cpu_d_i;
                    we    <= cpu_we_i;
                end
                default: begin
                    addr  <= dma_addr_i;
                    wdata <= dma_d_i;
                    we    <= dma_we_i;
                end
            endcase
        end
    end

    // Completion: read data, acks and cpu_done all become visible in the DONE cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cpu_d_o   <= '0;
            dma_d_o   <= '0;
            ld_ack_o  <= 1'b0;
            dma_ack_o <= 1'b0;
            cpu_done  <= 1'b0;
        end else begin
            ld_ack_o  <= 1'b0;
            dma_ack_o <= 1'b0;
            if (state == ACCESS && last) begin
                if (!we && id == REQ_CPU) cpu_d_o <= mem_d_i;
                if (!we && id == REQ_DMA) dma_d_o <= mem_d_i;
                ld_ack_o  <= (id == REQ_LD);
                dma_ack_o <= (id == REQ_DMA);
            end
            if (!cpu_req_i)
                cpu_done <= 1'b0;
            else if (state == ACCESS && last && id == REQ_CPU)
                cpu_done <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            starve <= '0;
        end else if (!dma_req_i) begin
            starve <= '0;
        end else if (state == IDLE) begin
            if (win_id == REQ_DMA)
                starve <= '0;
            else if (!starve_sat)
                starve <= starve + 1'b1;
        end
    end

endmodule
